cordic_ci_ctrl: RTL and testbench
=================================

Name: cordic_ci_ctrl

Overview:
Sequential front-end that feeds the combinational CORDIC cosine stage. It presents a Nios II multi-cycle custom-instruction handshake: it registers the fp32 operand and drives it onto the cosine input. It then waits a fixed settle budget, covered by the multicycle timing constraint on the 19-engine path, and captures the fp32 cosine output. The captured value is returned with a one-cycle done pulse. It sits between the CPU custom-instruction port and the cosine datapath.

Parameters:
SETTLE_CYCLES, 4, cycles from operand registration to result capture; must be >= 1; must match the multicycle constraint on the cosine path.
CNT_W, $clog2(SETTLE_CYCLES+1), width of the settle counter (derived; do not override).

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
clk_en  input  1  custom-instruction clock enable; low freezes all state.
start  input  1  operation request, sampled when clk_en=1.
dataa  input  32  fp32 angle operand (radians).
cos_angle  output  32  registered operand driven to the cosine stage input.
cos_result  input  32  fp32 result from the cosine stage (combinational from cos_angle).
result  output  32  captured fp32 cosine, held until the next capture.
done  output  1  one-cycle pulse: result valid.
busy  output  1  high from operand registration until capture.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, cnt=0, cos_angle=0, result=0, done=0, busy=0. All outputs are registered.
- clk_en=0: no register changes, including done, busy and cnt. start is not sampled.
- FSM states: IDLE, SETTLE.
- IDLE, on an edge with clk_en & start:
  - cos_angle<=dataa, cnt<=SETTLE_CYCLES-1, busy<=1, done<=0, go to SETTLE.
- IDLE with no start: done<=0 (clears the pulse).
- SETTLE, cnt!=0: cnt<=cnt-1.
- SETTLE, cnt==0: result<=cos_result, done<=1, busy<=0, go to IDLE.
- Latency: start sampled at enabled edge E0. done is high after enabled edge E0+SETTLE_CYCLES, for exactly one enabled cycle.
  - With clk_en stalls, latency counts only enabled edges.
- start while busy=1 is ignored. The operand is not latched and the operation in flight is unaffected. The CPU must not issue it; the bench checks this is harmless.
- Back-to-back: start in the cycle done=1 is accepted (state is IDLE). done clears on that edge, and the new operand is registered on the same edge.
- cos_angle is held constant throughout SETTLE. It changes only on an accepted start, so cos_result is stable at capture.
- result holds its value across idle periods and across ignored starts. It changes only on capture.
- Reset mid-SETTLE: aborts immediately. No done pulse is emitted for the aborted operation, and outputs take their reset values.
- No arithmetic on data. Special-value handling (NaN, inf, denormal, out-of-range angle) is the cosine stage's responsibility and is passed through verbatim.
- SETTLE_CYCLES=1: capture occurs on the edge after registration, so done is high one edge after the start edge is sampled.

Test Plan:
1. Reset, then start with dataa=0x00000000 (SETTLE_CYCLES=4) -> busy=1 for 4 edges; done=1 for exactly one cycle, 4 edges after the start edge; result=0x3F800000 ±1 ulp; cos_angle=0x00000000 throughout.
2. dataa=0x3F490FDB (pi/4) -> result=0x3F3504F3 ±2 ulp. Then dataa=0x3F860A92 (pi/3) issued in the done cycle -> accepted back-to-back; second result 0x3F000000 ±2 ulp, 4 edges later.
3. start with dataa=0x3F800000, second start with dataa=0x40000000 two cycles later while busy -> second ignored; cos_angle stays 0x3F800000; result≈0x3F0A5140 (cos 1.0); exactly one done pulse.
4. start, then clk_en=0 for 3 cycles mid-SETTLE -> cnt, busy and cos_angle frozen; done arrives 4 enabled edges after start, i.e. 7 clock edges total.
5. start, then assert reset_n=0 asynchronously two cycles later (between edges) -> outputs zero immediately; no done pulse after release; next start completes normally.
6. Rebuild with SETTLE_CYCLES=1; dataa=0xBF800000 -> done one edge after the start edge; result≈0x3F0A5140 (cos is even).

Source files
------------

// File: rtl/cordic_ci_if.sv
// Nios II multi-cycle custom-instruction handshake between the CPU port and the
// cosine front-end.
interface cordic_ci_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic        busy;

    modport master (output clk_en, start, dataa, input  result, done, busy);
    modport slave  (input  clk_en, start, dataa, output result, done, busy);
endinterface

// File: rtl/cordic_ci_ctrl.sv
// Sequential front-end for the combinational CORDIC cosine stage: registers the
// operand, waits a fixed settle budget, then captures and returns the cosine.
module cordic_ci_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    cordic_ci_if.slave  ci,
    output logic [31:0] cos_angle,
    input  logic [31:0] cos_result
);

    typedef enum logic {IDLE, SETTLE} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [31:0]        angle_q, angle_d;
    logic [31:0]        res_q,   res_d;
    logic               done_q,  done_d;
    logic               busy_q,  busy_d;

    // Starts seen in SETTLE fall through untouched, so an illegal CPU issue
    // cannot disturb the operand feeding the multicycle path.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        angle_d = angle_q;
        res_d   = res_q;
        done_d  = done_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (ci.start) begin
                    angle_d = ci.dataa;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_d   = cos_result;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // clk_en gates every register, so a stalled CPU freezes the settle count too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            angle_q <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (ci.clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            angle_q <= angle_d;
            res_q   <= res_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign cos_angle = angle_q;
    assign ci.result = res_q;
    assign ci.done   = done_q;
    assign ci.busy   = busy_q;

endmodule

// File: tb/tb_cordic_ci_ctrl.sv
// Scoreboard bench for cordic_ci_ctrl: stimulus pushes expected captures, monitors
// pop them on done and also track busy / cos_angle / result hold every cycle.
module tb_cordic_ci_ctrl;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    cordic_ci_if ci0();
    cordic_ci_if ci1();
    logic [31:0] ang0, ang1, cres0, cres1;

    // Stand-in cosine stage: spec reference points plus a deterministic scramble.
    function automatic logic [31:0] cosf(input logic [31:0] x);
        case (x)
            32'h0000_0000: cosf = 32'h3F80_0000;
            32'h3F49_0FDB: cosf = 32'h3F35_04F3;
            32'h3F86_0A92: cosf = 32'h3F00_0000;
            32'h3F80_0000: cosf = 32'h3F0A_5140;
            32'hBF80_0000: cosf = 32'h3F0A_5140;
            32'h4000_0000: cosf = 32'hBED5_1132;
            default:       cosf = {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign cres0 = cosf(ang0);
    assign cres1 = cosf(ang1);

    cordic_ci_ctrl #(.SETTLE_CYCLES(S)) dut0 (
        .clk(clk), .reset_n(reset_n), .ci(ci0), .cos_angle(ang0), .cos_result(cres0));
    cordic_ci_ctrl #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .ci(ci1), .cos_angle(ang1), .cos_result(cres1));

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct { logic [31:0] res; int edge_n; } exp_t;
    exp_t q0[$], q1[$];

    // Reference model in terms of enabled-edge indices.
    int ecnt = 0, cyc1 = 0;
    int k0 = -1;
    int last_done = -1;
    logic [31:0] m_ang = '0, m_res = '0;

    always @(posedge clk) begin
        if (ci0.clk_en && reset_n) ecnt++;
        if (reset_n) cyc1++;
    end

    always @(negedge clk) begin : mon0
        exp_t e;
        logic bexp;
        if (ci0.done && ecnt != last_done) begin
            last_done = ecnt;
            if (q0.size() == 0) chk("spurious_done", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk("result", ci0.result, e.res);
                chk("done_edge", 32'(ecnt), 32'(e.edge_n));
                m_res = e.res;
            end
        end
        bexp = (k0 >= 0) && (ecnt >= k0) && (ecnt < k0 + S);
        chk("busy", {31'b0, ci0.busy}, {31'b0, bexp});
        chk("cos_angle", ang0, m_ang);
        chk("result_hold", ci0.result, m_res);
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (ci1.done) begin
            if (q1.size() == 0) chk("s1_spurious_done", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk("s1_result", ci1.result, e.res);
                chk("s1_done_edge", 32'(cyc1), 32'(e.edge_n));
            end
        end
    end

    task automatic tick(input logic en, input logic st, input logic [31:0] d);
        ci0.clk_en = en; ci0.start = st; ci0.dataa = d;
        @(posedge clk); #1;
        if (en && st && reset_n && (k0 < 0 || ecnt > k0 + S)) begin
            k0 = ecnt;
            m_ang = d;
            q0.push_back('{cosf(d), ecnt + S});
        end
        ci0.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q0.size() != 0; i++) tick(1'b1, 1'b0, 32'h0);
        chk("drain_timeout", 32'(q0.size()), 32'd0);
        tick(1'b1, 1'b0, 32'h0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !ci0.done; i++) tick(1'b1, 1'b0, 32'h0);
        chk("wait_done_timeout", {31'b0, ci0.done}, 32'd1);
    endtask

    task automatic s1_op(input logic [31:0] d);
        ci1.start = 1'b1; ci1.dataa = d;
        @(posedge clk); #1;
        q1.push_back('{cosf(d), cyc1 + 1});
        ci1.start = 1'b0;
        for (int i = 0; i < 10 && q1.size() != 0; i++) begin @(posedge clk); #1; end
        chk("s1_timeout", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        ci0.clk_en = 1'b1; ci0.start = 1'b0; ci0.dataa = '0;
        ci1.clk_en = 1'b1; ci1.start = 1'b0; ci1.dataa = '0;
        #1;
        chk("rst_result", ci0.result, 32'h0);
        chk("rst_busy", {31'b0, ci0.busy}, 32'd0);
        chk("rst_done", {31'b0, ci0.done}, 32'd0);
        chk("rst_cos_angle", ang0, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        tick(1'b1, 1'b0, 32'h0);

        // cos(0)
        tick(1'b1, 1'b1, 32'h0000_0000);
        drain();

        // pi/4 then pi/3 issued in the done cycle
        tick(1'b1, 1'b1, 32'h3F49_0FDB);
        wait_done();
        tick(1'b1, 1'b1, 32'h3F86_0A92);
        drain();

        // start while busy is ignored
        tick(1'b1, 1'b1, 32'h3F80_0000);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h4000_0000);
        drain();

        // clk_en stall mid-settle, including a start that must not be sampled
        tick(1'b1, 1'b1, 32'h4049_0FDB);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h1234_5678);
        tick(1'b0, 1'b0, 32'h0);
        drain();

        // async reset mid-settle
        tick(1'b1, 1'b1, 32'h3E80_0000);
        tick(1'b1, 1'b0, 32'h0);
        #3;
        reset_n = 1'b0;
        k0 = -1; m_ang = '0; m_res = '0; q0.delete();
        #1;
        chk("abort_result", ci0.result, 32'h0);
        chk("abort_busy", {31'b0, ci0.busy}, 32'd0);
        chk("abort_cos_angle", ang0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        reset_n = 1'b1;
        repeat (6) tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h3F49_0FDB);
        drain();

        // randomized traffic with stalls and illegal starts
        for (int i = 0; i < 300; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
        drain();

        // SETTLE_CYCLES = 1 instance
        s1_op(32'hBF80_0000);
        s1_op(32'h3F80_0000);
        s1_op($urandom);

        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
